// File: rtl/packet_req_agent_pkg.sv
// Shared definitions for the packet requester agent.
//   state_t  : agent FSM encoding (IDLE = 1'b0, SEND = 1'b1)
//   clog2_f  : ceiling log2, used to size pointers and the credit counter
package packet_req_agent_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Number of flag bits carried with each buffered flit: {hdr, tail}
  localparam int FLAG_W = 2;

  function automatic int clog2_f(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 <<< i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/packet_req_agent_flit_fifo.sv
// Synchronous flit buffer with show-ahead head output.
// Ports:
//   clk, reset     clock, asynchronous active-low reset (clears pointers)
//   wr, din        write strobe and data; ignored while full
//   rd             pop strobe; ignored while empty
//   dout           current head entry (valid only when !empty)
//   full, empty    status, derived from registered pointers only
import packet_req_agent_pkg::*;

module flit_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr,
  input  logic [WIDTH-1:0] din,
  input  logic             rd,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = clog2_f(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // One extra pointer bit distinguishes full from empty when indices match
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             push;
  logic             pop;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign push  = wr & ~full;
  assign pop   = rd & ~empty;
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage needs no reset: contents are only observed while !empty
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/packet_req_agent.sv
// Requester-side agent for a round-robin arbiter input. Buffers incoming
// flits, requests the arbiter for whole packets, forwards one flit per
// granted cycle under downstream credit control, and pulses priority_en
// when the tail leaves so the arbiter rotates only at packet boundaries.
// Ports:
//   clk, reset                        clock, asynchronous active-low reset
//   flit_in, flit_in_hdr/_tail/_wr    upstream flit write interface
//   fifo_full                         buffer full (writes dropped)
//   request, grant, priority_en       arbiter handshake
//   flit_out, flit_out_hdr/_tail/_wr  registered downstream interface
//   credit_in                         downstream returned one slot
//   proto_err                         registered one-cycle error pulse
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | between packets; request only for a header at head with credit
// SEND  | packet in flight; request held until the tail is forwarded
import packet_req_agent_pkg::*;

module packet_req_agent #(
  parameter int FLIT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CREDIT_MAX = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [FLIT_WIDTH-1:0] flit_in,
  input  logic                  flit_in_hdr,
  input  logic                  flit_in_tail,
  input  logic                  flit_in_wr,
  output logic                  fifo_full,
  output logic                  request,
  input  logic                  grant,
  output logic                  priority_en,
  output logic [FLIT_WIDTH-1:0] flit_out,
  output logic                  flit_out_hdr,
  output logic                  flit_out_tail,
  output logic                  flit_out_wr,
  input  logic                  credit_in,
  output logic                  proto_err
);

  localparam int CW = clog2_f(CREDIT_MAX + 1);
  localparam int EW = FLIT_WIDTH + FLAG_W;

  state_t          state;
  logic [CW-1:0]   credit;
  logic [EW-1:0]   head;
  logic            fifo_empty;
  logic            head_hdr;
  logic            head_tail;
  logic            credit_ok;
  logic            send;
  logic            discard;
  logic            err_now;

  flit_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .wr    (flit_in_wr),
    .din   ({flit_in_hdr, flit_in_tail, flit_in}),
    .rd    (send | discard),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign head_hdr  = head[EW-1];
  assign head_tail = head[EW-2];
  assign credit_ok = (credit != '0);

  always_comb begin
    request = 1'b0;
    if (state == SEND) request = 1'b1;
    else               request = ~fifo_empty & head_hdr & credit_ok;
  end

  assign send        = request & grant & ~fifo_empty & credit_ok;
  // A body flit at head outside a packet has no owner: drop it
  assign discard     = (state == IDLE) & ~fifo_empty & ~head_hdr;
  assign priority_en = send & head_tail;

  // Overflow counts even if a pop frees a slot in the same cycle
  assign err_now = (flit_in_wr & fifo_full)
                 | discard
                 | (send & (state == SEND) & head_hdr)
                 | (credit_in & ~send & (credit == CW'(CREDIT_MAX)));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      credit        <= CW'(CREDIT_MAX);
      flit_out      <= '0;
      flit_out_hdr  <= 1'b0;
      flit_out_tail <= 1'b0;
      flit_out_wr   <= 1'b0;
      proto_err     <= 1'b0;
    end else begin
      proto_err   <= err_now;
      flit_out_wr <= send;

      if (send) begin
        flit_out      <= head[FLIT_WIDTH-1:0];
        flit_out_hdr  <= head_hdr;
        flit_out_tail <= head_tail;
      end

      // Simultaneous send and return cancel out
      if (send && !credit_in) begin
        credit <= credit - 1'b1;
      end else if (!send && credit_in && credit != CW'(CREDIT_MAX)) begin
        credit <= credit + 1'b1;
      end

      case (state)
        IDLE:    if (send && !head_tail) state <= SEND;
        SEND:    if (send && head_tail)  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
